// File: rtl/mdu_unit_if.sv
// Handshake/bus bundle between the E-stage issue logic and the multiply/divide unit.
// Master drives the op request; slave returns busy and the HI/LO registers.
interface mdu_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic             cancel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, cancel, a, b, input busy, hi, lo);
  modport slave  (input start, op, cancel, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu_unit.sv
// MIPS multiply/divide unit with HI/LO: MULT/DIV busy for MULT_CYCLES/DIV_CYCLES then commit,
// MTHI/MTLO write in one edge; no backpressure, starts outside IDLE are dropped (HAZARD stalls D).
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_unit_if.slave  mdu
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
  logic [1:0]         r_op;
  logic               w_capture, w_commit, w_mt_hi, w_mt_lo;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_commit    = 1'b0;
    w_mt_hi     = 1'b0;
    w_mt_lo     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mdu.start && !mdu.cancel) begin
          case (mdu.op)
            3'b000, 3'b001: begin
              w_capture   = 1'b1;
              w_cnt_nxt   = CNT_W'(MULT_CYCLES);
              w_state_nxt = S_RUN;
            end
            3'b010, 3'b011: begin
              w_capture   = 1'b1;
              w_cnt_nxt   = CNT_W'(DIV_CYCLES);
              w_state_nxt = S_RUN;
            end
            3'b100:  w_mt_hi = 1'b1;
            3'b101:  w_mt_lo = 1'b1;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // cancel is deliberately ignored here: the issuing instruction already committed
        if (r_cnt == CNT_W'(1)) begin
          w_commit    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Result is formed from the captured operands; r_op[1]=divide, r_op[0]=unsigned.
  logic [2*WIDTH-1:0] w_a_ext, w_b_ext, w_prod;
  logic               w_a_neg, w_b_neg, w_b_zero;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_q_mag, w_r_mag, w_quo, w_rem;
  logic [WIDTH-1:0]   w_res_hi, w_res_lo;
  logic               w_res_vld;

  always_comb begin
    w_a_ext  = r_op[0] ? {{WIDTH{1'b0}}, r_a} : {{WIDTH{r_a[WIDTH-1]}}, r_a};
    w_b_ext  = r_op[0] ? {{WIDTH{1'b0}}, r_b} : {{WIDTH{r_b[WIDTH-1]}}, r_b};
    w_prod   = w_a_ext * w_b_ext;

    w_a_neg  = !r_op[0] && r_a[WIDTH-1];
    w_b_neg  = !r_op[0] && r_b[WIDTH-1];
    w_b_zero = (r_b == '0);
    // The minimum value negates to itself, which is its correct unsigned magnitude.
    w_a_mag  = w_a_neg ? (~r_a + WIDTH'(1)) : r_a;
    w_b_mag  = w_b_neg ? (~r_b + WIDTH'(1)) : r_b;
    w_q_mag  = '0;
    w_r_mag  = '0;
    if (!w_b_zero) begin
      w_q_mag = w_a_mag / w_b_mag;
      w_r_mag = w_a_mag % w_b_mag;
    end
    w_quo    = (w_a_neg ^ w_b_neg) ? (~w_q_mag + WIDTH'(1)) : w_q_mag;
    w_rem    = w_a_neg ? (~w_r_mag + WIDTH'(1)) : w_r_mag;

    w_res_vld = !(r_op[1] && w_b_zero);
    w_res_hi  = r_op[1] ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    w_res_lo  = r_op[1] ? w_quo : w_prod[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= '0;
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_capture) begin
        r_a  <= mdu.a;
        r_b  <= mdu.b;
        r_op <= mdu.op[1:0];
      end
      if (w_mt_hi) r_hi <= mdu.a;
      if (w_mt_lo) r_lo <= mdu.a;
      if (w_commit && w_res_vld) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

  assign mdu.busy = (r_state == S_RUN);
  assign mdu.hi   = r_hi;
  assign mdu.lo   = r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed vector table plus hand sequences for the 32-bit unit; model-checked sweep of an 8-bit unit.
module tb_mdu_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mdu_unit_if #(.WIDTH(32)) if32();
  mdu_unit_if #(.WIDTH(8))  if8();

  mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
    .clk(clk), .reset(reset), .mdu(if32)
  );
  mdu_unit #(.WIDTH(8), .MULT_CYCLES(1), .DIV_CYCLES(3)) u_dut8 (
    .clk(clk), .reset(reset), .mdu(if8)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Counts remaining busy cycles after the accept edge; flags any HI/LO movement while busy.
  task automatic run32(output int n, output bit moved);
    logic [31:0] ph, pl;
    ph = if32.hi;
    pl = if32.lo;
    n = 0;
    moved = 1'b0;
    while (if32.busy && n < 100) begin
      tick();
      n++;
      if (if32.busy && (if32.hi !== ph || if32.lo !== pl)) moved = 1'b1;
    end
  endtask

  task automatic run8(output int n);
    n = 0;
    while (if8.busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if32.start = 1'b1;
    if32.op    = op;
    if32.a     = a;
    if32.b     = b;
    tick();
    if32.start = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int   n;
    bit   moved;
    logic [7:0]  a8, b8, ehi8, elo8;
    logic [2:0]  op8;
    int   sa, sb, ua, ub, p, q, r;

    vecs[0]  = '{3'b000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{3'b011, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5]  = '{3'b101, 32'h12345678, 32'h00000000, 32'h00000000, 32'h12345678, 0};
    vecs[6]  = '{3'b100, 32'hCAFEF00D, 32'h00000000, 32'hCAFEF00D, 32'h12345678, 0};
    vecs[7]  = '{3'b011, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
    vecs[8]  = '{3'b000, 32'hFFFF0000, 32'h7FFFFFFF, 32'hFFFF8000, 32'h00010000, 5};
    vecs[9]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[10] = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[11] = '{3'b110, 32'h00000005, 32'h00000003, 32'h00000001, 32'hFFFFFFFD, 0};

    if32.start = 1'b0; if32.op = 3'b000; if32.cancel = 1'b0; if32.a = '0; if32.b = '0;
    if8.start  = 1'b0; if8.op  = 3'b000; if8.cancel  = 1'b0; if8.a  = '0; if8.b  = '0;

    #1;
    chk("reset_busy", 64'(if32.busy), 64'd0);
    chk("reset_hi", 64'(if32.hi), 64'd0);
    chk("reset_lo", 64'(if32.lo), 64'd0);
    #21 reset = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      issue32(vecs[i].op, vecs[i].a, vecs[i].b);
      run32(n, moved);
      chk($sformatf("v%0d_busy_cycles", i), 64'(n), 64'(vecs[i].n));
      chk($sformatf("v%0d_hold", i), 64'(moved), 64'd0);
      chk($sformatf("v%0d_hi", i), 64'(if32.hi), 64'(vecs[i].hi));
      chk($sformatf("v%0d_lo", i), 64'(if32.lo), 64'(vecs[i].lo));
    end

    // start masked by cancel in the same cycle
    if32.cancel = 1'b1;
    issue32(3'b000, 32'd3, 32'd3);
    if32.cancel = 1'b0;
    chk("cancel_busy", 64'(if32.busy), 64'd0);
    tick();
    chk("cancel_hi", 64'(if32.hi), 64'h00000001);
    chk("cancel_lo", 64'(if32.lo), 64'hFFFFFFFD);

    // cancel pulsed mid-run does not abort
    issue32(3'b000, 32'd3, 32'd5);
    tick();
    if32.cancel = 1'b1;
    tick();
    if32.cancel = 1'b0;
    chk("cancel_run_busy", 64'(if32.busy), 64'd1);
    run32(n, moved);
    chk("cancel_run_cycles", 64'(n), 64'd3);
    chk("cancel_run_hi", 64'(if32.hi), 64'd0);
    chk("cancel_run_lo", 64'(if32.lo), 64'd15);

    // MTHI while busy is dropped; the divide result still lands
    issue32(3'b011, 32'd20, 32'd3);
    tick();
    issue32(3'b100, 32'hDEADBEEF, 32'd0);
    run32(n, moved);
    chk("mthi_busy_hold", 64'(moved), 64'd0);
    chk("mthi_busy_hi", 64'(if32.hi), 64'd2);
    chk("mthi_busy_lo", 64'(if32.lo), 64'd6);

    // start in the final busy cycle is ignored; held one more cycle it is accepted
    issue32(3'b001, 32'd2, 32'd3);
    repeat (4) tick();
    chk("final_cycle_busy", 64'(if32.busy), 64'd1);
    if32.start = 1'b1; if32.op = 3'b101; if32.a = 32'h55;
    tick();
    chk("final_cycle_ignored_busy", 64'(if32.busy), 64'd0);
    chk("final_cycle_ignored_lo", 64'(if32.lo), 64'd6);
    tick();
    if32.start = 1'b0;
    chk("held_start_lo", 64'(if32.lo), 64'h55);
    chk("held_start_busy", 64'(if32.busy), 64'd0);

    // reset in the third busy cycle of a divide
    issue32(3'b010, 32'd100, 32'd3);
    tick();
    tick();
    chk("pre_reset_busy", 64'(if32.busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("midrst_busy", 64'(if32.busy), 64'd0);
    chk("midrst_hi", 64'(if32.hi), 64'd0);
    chk("midrst_lo", 64'(if32.lo), 64'd0);
    tick();
    tick();
    reset = 1'b1;
    repeat (12) tick();
    chk("postrst_busy", 64'(if32.busy), 64'd0);
    chk("postrst_hi", 64'(if32.hi), 64'd0);
    chk("postrst_lo", 64'(if32.lo), 64'd0);

    // 8-bit sweep against an integer-arithmetic model
    ehi8 = '0;
    elo8 = '0;
    for (int i = 0; i < 24; i++) begin
      op8 = 3'($urandom_range(0, 3));
      a8  = 8'($urandom_range(0, 255));
      b8  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) b8 = 8'h00;
      if (i == 0) begin op8 = 3'b010; a8 = 8'h80; b8 = 8'hFF; end
      if (i == 1) begin op8 = 3'b000; a8 = 8'h80; b8 = 8'h80; end
      sa = $signed(a8);
      sb = $signed(b8);
      ua = int'(a8);
      ub = int'(b8);
      case (op8)
        3'b000: begin p = sa * sb; ehi8 = p[15:8]; elo8 = p[7:0]; end
        3'b001: begin p = ua * ub; ehi8 = p[15:8]; elo8 = p[7:0]; end
        3'b010: if (sb != 0) begin q = sa / sb; r = sa % sb; ehi8 = r[7:0]; elo8 = q[7:0]; end
        default: if (ub != 0) begin q = ua / ub; r = ua % ub; ehi8 = r[7:0]; elo8 = q[7:0]; end
      endcase
      if8.start = 1'b1; if8.op = op8; if8.a = a8; if8.b = b8;
      tick();
      if8.start = 1'b0;
      run8(n);
      chk($sformatf("w8_%0d_op%0d_cycles", i, op8), 64'(n), (op8[1] ? 64'd3 : 64'd1));
      chk($sformatf("w8_%0d_op%0d_hi(a=%h b=%h)", i, op8, a8, b8), 64'(if8.hi), 64'(ehi8));
      chk($sformatf("w8_%0d_op%0d_lo(a=%h b=%h)", i, op8, a8, b8), 64'(if8.lo), 64'(elo8));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
